// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use and branch-operand stalls, with ID redirect squash.
// Optional HAZARD_STALL_CNT_EN macro adds a saturating 16-bit stall_count output.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs_id,
  input  logic [REG_ADDR_W-1:0] rt_id,
  input  logic                  uses_rs_id,
  input  logic                  uses_rt_id,
  input  logic                  branch_id,
  input  logic                  pc_src_id,
  input  logic [REG_ADDR_W-1:0] rd_ex,
  input  logic                  reg_write_ex,
  input  logic [1:0]            mem_to_reg_ex,
  input  logic [REG_ADDR_W-1:0] rd_mem,
  input  logic                  mem_read_mem,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  flush_ex,
  output logic                  flush_id,
  output logic                  hazard_busy
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [15:0]           stall_count
`endif
);

  typedef enum logic {IDLE, LOAD_STALL} state_t;

  localparam logic [2:0] CNT_INIT = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic       MULTI    = (LOAD_STALL_CYCLES > 1);

  state_t     state;
  logic [2:0] cnt;
  logic       load_haz, br_haz, stall;

  // r0 is hard-wired zero, so it can never be a real producer.
  function automatic logic src_match(input logic [REG_ADDR_W-1:0] dest);
    logic m_rs, m_rt;
    m_rs = uses_rs_id && (rs_id == dest) && (dest != '0);
    m_rt = uses_rt_id && (rt_id == dest) && (dest != '0);
    return m_rs || m_rt;
  endfunction

  always_comb begin
    load_haz = (mem_to_reg_ex == 2'b01) && src_match(rd_ex);
    br_haz   = branch_id && ((reg_write_ex && src_match(rd_ex)) ||
                             (mem_read_mem && src_match(rd_mem)));
  end

  always_comb begin
    stall = 1'b0;
    if (!reset) stall = (state == LOAD_STALL) || load_haz || br_haz;
  end

  assign stall_if    = stall;
  assign stall_id    = stall;
  assign flush_ex    = stall;
  assign flush_id    = !reset && pc_src_id && !stall;
  assign hazard_busy = !reset && (state == LOAD_STALL);

  // The first stall cycle is spent in IDLE; LOAD_STALL covers the remaining ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (load_haz && MULTI) begin
            state <= LOAD_STALL;
            cnt   <= CNT_INIT;
          end
        end
        LOAD_STALL: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset)                                 stall_cnt_q <= 16'd0;
    else if (stall_id && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign stall_count = reset ? 16'd0 : stall_cnt_q;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-specifier width.
REQ-002 SHALL have parameter LOAD_STALL_CYCLES, default 1, legal 1..7, total stall cycles per load-use hazard.
REQ-003 SHALL have ports: clk  in  1  single clock; reset  in  1  synchronous, active-high.
REQ-004 SHALL have ports: rs_id, rt_id  in  REG_ADDR_W  ID-stage source specifiers; uses_rs_id, uses_rt_id  in  1  source actually read.
REQ-005 SHALL have ports: branch_id  in  1  ID instruction compares operands in ID (beq/bne/jr); pc_src_id  in  1  ID redirect taken.
REQ-006 SHALL have ports: rd_ex  in  REG_ADDR_W  EX destination; reg_write_ex  in  1; mem_to_reg_ex  in  2  (2'b01 = load).
REQ-007 SHALL have ports: rd_mem  in  REG_ADDR_W  MEM destination; mem_read_mem  in  1  load in MEM.
REQ-008 SHALL have outputs, 1 bit each: stall_if, stall_id (hold PC and IF/ID), flush_ex (bubble into ID/EX), flush_id (squash IF/ID), hazard_busy (FSM not IDLE).

Function
REQ-009 Match rule: mX = usesX && (X == dest) && dest != 0, X in {rs_id, rt_id}; match = m_rs || m_rt.
REQ-010 load_haz = (mem_to_reg_ex == 2'b01) && match(rd_ex).
REQ-011 br_haz = branch_id && ((reg_write_ex && match(rd_ex)) || (mem_read_mem && match(rd_mem))).
REQ-012 FSM states: IDLE, LOAD_STALL; 3-bit down-counter cnt.
REQ-013 IDLE: stall = load_haz || br_haz, combinational, same cycle.
REQ-014 IDLE -> LOAD_STALL when load_haz && LOAD_STALL_CYCLES > 1; cnt loaded with LOAD_STALL_CYCLES-1.
REQ-015 LOAD_STALL: stall = 1 unconditionally; detection inputs ignored; cnt decrements each cycle; -> IDLE on the cycle after cnt == 1.
REQ-016 Load-use hazard total stall length SHALL be exactly LOAD_STALL_CYCLES cycles; branch-on-load SHALL re-evaluate in IDLE afterwards (load now in MEM) giving one extra cycle via br_haz.
REQ-017 stall_if = stall_id = flush_ex = stall.
REQ-018 flush_id = pc_src_id && !stall; stall has priority over redirect.
REQ-019 hazard_busy = (state == LOAD_STALL).
REQ-020 Destination register 0 SHALL never cause a hazard.

Reset
REQ-021 reset sampled at rising clk; state -> IDLE, cnt -> 0.
REQ-022 While reset is high all outputs SHALL be 0 regardless of inputs, including mid-LOAD_STALL.
REQ-023 First cycle after reset deassertion behaves as IDLE.

Configuration
REQ-024 Macro HAZARD_STALL_CNT_EN defined: extra output stall_count  out  16, increments each cycle stall_id = 1, saturates at 16'hFFFF, cleared by reset.
REQ-025 HAZARD_STALL_CNT_EN undefined: no stall_count port, no counter logic; all other behaviour identical.

Verification
REQ-026 LOAD_STALL_CYCLES=1: mem_to_reg_ex=01, rd_ex=8, rs_id=8, uses_rs_id=1 -> stall_if/stall_id/flush_ex=1 for 1 cycle, hazard_busy stays 0.
REQ-027 LOAD_STALL_CYCLES=3, same load-use -> stall high exactly 3 cycles, hazard_busy high cycles 2-3, inputs changed during stall ignored.
REQ-028 branch_id=1, rs_id=9, reg_write_ex=1, rd_ex=9, mem_to_reg_ex=00 -> 1 stall; next cycle rd_ex=0, mem_read_mem=0 -> stall 0, pc_src_id=1 gives flush_id=1.
REQ-029 rd_ex=0 with load, rs_id=0 -> no stall; pc_src_id=1 concurrently with load_haz -> flush_id=0.
REQ-030 LOAD_STALL_CYCLES=4, reset asserted in 2nd stall cycle -> all outputs 0 that cycle, IDLE after; with HAZARD_STALL_CNT_EN stall_count=0.
